id_stage_pipe: RTL

Parametrised, pipelined successor to the decode stage of the five-stage CPU. It holds the IF/ID register, reads a `2**RA_W`-entry register file, and selects register operands from EX, MEM or WB results, taking the newest one. It detects load-use hazards and stalls the front end for them. It resolves branches and jumps in ID and squashes the wrong-path fetch. The decoded instruction is registered into an ID/EX register.

---
 rtl/id_stage_pipe_if.sv | 57 +++++
 rtl/id_stage_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe_if.sv
// Bundle of fetch, forwarding, write-back and ID/EX signals around the decode stage.
// The pipeline side uses master and the decode stage uses slave.
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc4;
  logic [31:0]     f_inst;
  logic            stall;
  logic [1:0]      pcsource;
  logic [XLEN-1:0] bpc;
  logic [XLEN-1:0] jpc;
  logic            ex_wreg;
  logic            ex_m2reg;
  logic [RA_W-1:0] ex_rn;
  logic [XLEN-1:0] ex_alu;
  logic            mem_wreg;
  logic            mem_m2reg;
  logic [RA_W-1:0] mem_rn;
  logic [XLEN-1:0] mem_alu;
  logic [XLEN-1:0] mem_mo;
  logic            w_wreg;
  logic [RA_W-1:0] w_rn;
  logic [XLEN-1:0] wdi;
  logic            e_valid;
  logic            e_wreg;
  logic            e_m2reg;
  logic            e_wmem;
  logic            e_aluimm;
  logic            e_shift;
  logic [2:0]      e_aluc;
  logic [XLEN-1:0] e_a;
  logic [XLEN-1:0] e_b;
  logic [XLEN-1:0] e_imm;
  logic [RA_W-1:0] e_rn;

  modport master (
    output f_valid, f_pc4, f_inst,
    input  stall, pcsource, bpc, jpc,
    output ex_wreg, ex_m2reg, ex_rn, ex_alu,
    output mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_mo,
    output w_wreg, w_rn, wdi,
    input  e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc,
    input  e_a, e_b, e_imm, e_rn
  );

  modport slave (
    input  f_valid, f_pc4, f_inst,
    output stall, pcsource, bpc, jpc,
    input  ex_wreg, ex_m2reg, ex_rn, ex_alu,
    input  mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_mo,
    input  w_wreg, w_rn, wdi,
    output e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc,
    output e_a, e_b, e_imm, e_rn
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: IF/ID register, register file with EX/MEM/WB operand
// forwarding, load-use stall, branch/jump resolution in ID and the ID/EX register.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic         clk,
  input logic         clrn,
  id_stage_pipe_if.slave bus
);
  localparam int NREG = 2 ** RA_W;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [2:0] aluc;
    logic       regrt;
    logic       aluimm;
    logic       sext;
    logic [1:0] pcsource;
    logic       shift;
  } ctrl_t;

  function automatic ctrl_t control_unit(input logic [5:0] op, input logic [5:0] func,
                                         input logic rsrtequ);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          6'h20:   begin c.wreg = 1'b1; c.aluc = 3'b000; end
          6'h22:   begin c.wreg = 1'b1; c.aluc = 3'b100; end
          6'h24:   begin c.wreg = 1'b1; c.aluc = 3'b001; end
          6'h25:   begin c.wreg = 1'b1; c.aluc = 3'b101; end
          6'h26:   begin c.wreg = 1'b1; c.aluc = 3'b010; end
          6'h00:   begin c.wreg = 1'b1; c.aluc = 3'b011; c.shift = 1'b1; end
          6'h02:   begin c.wreg = 1'b1; c.aluc = 3'b111; c.shift = 1'b1; end
          6'h03:   begin c.wreg = 1'b1; c.aluc = 3'b110; c.shift = 1'b1; end
          6'h08:   c.pcsource = 2'b10;
          default: c = '0;
        endcase
      end
      OP_ADDI: begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; end
      OP_ANDI: begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = 3'b001; end
      OP_ORI:  begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = 3'b101; end
      OP_XORI: begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = 3'b010; end
      OP_LUI:  begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = 3'b110; end
      OP_LW:   begin
        c.wreg = 1'b1; c.m2reg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1;
      end
      OP_SW:   begin c.wmem = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; end
      OP_BEQ:  begin
        c.sext = 1'b1; c.aluc = 3'b010; c.pcsource = rsrtequ ? 2'b01 : 2'b00;
      end
      OP_BNE:  begin
        c.sext = 1'b1; c.aluc = 3'b010; c.pcsource = rsrtequ ? 2'b00 : 2'b01;
      end
      OP_J:    c.pcsource = 2'b11;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [RA_W-1:0] reg_field(input logic [4:0] f);
    logic [31:0] w;
    w = {27'd0, f};
    return w[RA_W-1:0];
  endfunction

  logic            d_valid_r;
  logic [XLEN-1:0] d_pc4_r;
  logic [31:0]     d_inst_r;
  logic [XLEN-1:0] rf_r [NREG];

  logic [RA_W-1:0] rs_s, rt_s, rd_s, ern_s;
  logic [RA_W-1:0] src_rn_s [2];
  logic [XLEN-1:0] src_op_s [2];
  logic [XLEN-1:0] imm_s;
  logic            rsrtequ_s, rt_src_s, stall_s;
  logic [1:0]      pcsrc_s;
  ctrl_t           ctrl_s;

  logic            e_valid_r, e_wreg_r, e_m2reg_r, e_wmem_r, e_aluimm_r, e_shift_r;
  logic [2:0]      e_aluc_r;
  logic [XLEN-1:0] e_a_r, e_b_r, e_imm_r;
  logic [RA_W-1:0] e_rn_r;

  assign rs_s        = reg_field(d_inst_r[9:5]);
  assign rt_s        = reg_field(d_inst_r[4:0]);
  assign rd_s        = reg_field(d_inst_r[14:10]);
  assign src_rn_s[0] = rs_s;
  assign src_rn_s[1] = rt_s;

  // Operand select: newest producer wins (EX non-load, then MEM, then WB write-through).
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (src_rn_s[k] == {RA_W{1'b0}}) begin
        src_op_s[k] = {XLEN{1'b0}};
      end else if (bus.ex_wreg && !bus.ex_m2reg && (bus.ex_rn == src_rn_s[k])) begin
        src_op_s[k] = bus.ex_alu;
      end else if (bus.mem_wreg && (bus.mem_rn == src_rn_s[k])) begin
        src_op_s[k] = bus.mem_m2reg ? bus.mem_mo : bus.mem_alu;
      end else if (bus.w_wreg && (bus.w_rn == src_rn_s[k])) begin
        src_op_s[k] = bus.wdi;
      end else begin
        src_op_s[k] = rf_r[src_rn_s[k]];
      end
    end
  end

  // Decode, hazard detection and next-PC selection.
  always_comb begin
    rsrtequ_s = (src_op_s[0] == src_op_s[1]);
    ctrl_s    = control_unit(d_inst_r[31:26], d_inst_r[25:20], rsrtequ_s);
    rt_src_s  = !ctrl_s.regrt || ctrl_s.wmem || (ctrl_s.pcsource == 2'b01);
    stall_s   = d_valid_r && bus.ex_wreg && bus.ex_m2reg && (bus.ex_rn != {RA_W{1'b0}}) &&
                ((bus.ex_rn == rs_s) || (rt_src_s && (bus.ex_rn == rt_s)));
    pcsrc_s   = (d_valid_r && !stall_s) ? ctrl_s.pcsource : 2'b00;
    imm_s     = ctrl_s.sext ? {{(XLEN-16){d_inst_r[25]}}, d_inst_r[25:10]}
                            : {{(XLEN-16){1'b0}}, d_inst_r[25:10]};
    ern_s     = ctrl_s.regrt ? rt_s : rd_s;
  end

  assign bus.stall    = stall_s;
  assign bus.pcsource = pcsrc_s;
  assign bus.bpc      = d_pc4_r + {imm_s[XLEN-3:0], 2'b00};
  assign bus.jpc      = {d_pc4_r[XLEN-1:28], d_inst_r[25:0], 2'b00};

  // Register file; r0 is never written.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < NREG; i++) rf_r[i] <= {XLEN{1'b0}};
    end else if (bus.w_wreg && (bus.w_rn != {RA_W{1'b0}})) begin
      rf_r[bus.w_rn] <= bus.wdi;
    end
  end

  // IF/ID register: holds on stall, squashes the wrong-path fetch on redirect.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      d_valid_r <= 1'b0;
      d_pc4_r   <= {XLEN{1'b0}};
      d_inst_r  <= 32'd0;
    end else if (!stall_s) begin
      d_valid_r <= (pcsrc_s == 2'b00) ? bus.f_valid : 1'b0;
      d_pc4_r   <= bus.f_pc4;
      d_inst_r  <= bus.f_inst;
    end
  end

  // ID/EX register: a bubble while stalled, the decoded instruction otherwise.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      e_valid_r  <= 1'b0;
      e_wreg_r   <= 1'b0;
      e_m2reg_r  <= 1'b0;
      e_wmem_r   <= 1'b0;
      e_aluimm_r <= 1'b0;
      e_shift_r  <= 1'b0;
      e_aluc_r   <= 3'd0;
      e_a_r      <= {XLEN{1'b0}};
      e_b_r      <= {XLEN{1'b0}};
      e_imm_r    <= {XLEN{1'b0}};
      e_rn_r     <= {RA_W{1'b0}};
    end else if (stall_s) begin
      e_valid_r  <= 1'b0;
      e_wreg_r   <= 1'b0;
      e_m2reg_r  <= 1'b0;
      e_wmem_r   <= 1'b0;
      e_aluimm_r <= 1'b0;
      e_shift_r  <= 1'b0;
      e_aluc_r   <= 3'd0;
    end else begin
      e_valid_r  <= d_valid_r;
      e_wreg_r   <= d_valid_r & ctrl_s.wreg;
      e_m2reg_r  <= d_valid_r & ctrl_s.m2reg;
      e_wmem_r   <= d_valid_r & ctrl_s.wmem;
      e_aluimm_r <= d_valid_r & ctrl_s.aluimm;
      e_shift_r  <= d_valid_r & ctrl_s.shift;
      e_aluc_r   <= d_valid_r ? ctrl_s.aluc : 3'd0;
      e_a_r      <= src_op_s[0];
      e_b_r      <= src_op_s[1];
      e_imm_r    <= imm_s;
      e_rn_r     <= ern_s;
    end
  end

  assign bus.e_valid  = e_valid_r;
  assign bus.e_wreg   = e_wreg_r;
  assign bus.e_m2reg  = e_m2reg_r;
  assign bus.e_wmem   = e_wmem_r;
  assign bus.e_aluimm = e_aluimm_r;
  assign bus.e_shift  = e_shift_r;
  assign bus.e_aluc   = e_aluc_r;
  assign bus.e_a      = e_a_r;
  assign bus.e_b      = e_b_r;
  assign bus.e_imm    = e_imm_r;
  assign bus.e_rn     = e_rn_r;
endmodule
